// File: rtl/key_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : key_cmd_scheduler
// Purpose  : Turns single-cycle key pulses and a level-dependent gravity tick
//            into a stream of game commands with a valid/ready handshake.
//            Three stages: sticky per-key pending bits, a small command FIFO
//            and an output register arbitrating FIFO head against DROP.
// Ports    : clk_i        - clock, rising edge
//            reset_i      - synchronous active-high reset
//            left_i, right_i, rotate_i, start_i - key-edge pulses
//            level_i[3:0] - game level, sampled at each gravity reload
//            lose_i       - game-over from game logic
//            cmd_ready_i  - consumer accepts cmd_o this cycle
//            cmd_v_o      - cmd_o valid
//            cmd_o[2:0]   - 1 LEFT, 2 RIGHT, 3 ROTATE, 4 START, 5 DROP
//            state_o[1:0] - 0 IDLE, 1 PLAY, 2 OVER
// Revision : 1.0 - initial release
// ============================================================================
module key_cmd_scheduler #(
  parameter int fifo_depth_p  = 4,
  parameter int base_period_p = 64,
  parameter int step_p        = 4,
  parameter int min_period_p  = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       rotate_i,
  input  logic       start_i,
  input  logic [3:0] level_i,
  input  logic       lose_i,
  input  logic       cmd_ready_i,
  output logic       cmd_v_o,
  output logic [2:0] cmd_o,
  output logic [1:0] state_o
);

  localparam int c_ADDR_W   = $clog2(fifo_depth_p);
  localparam int c_PER_MAX  = (base_period_p > min_period_p) ? base_period_p : min_period_p;
  localparam int c_CNT_W    = $clog2(c_PER_MAX + 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_PLAY = 2'd1;
  localparam logic [1:0] c_ST_OVER = 2'd2;

  localparam logic [2:0] c_CMD_NONE   = 3'd0;
  localparam logic [2:0] c_CMD_LEFT   = 3'd1;
  localparam logic [2:0] c_CMD_RIGHT  = 3'd2;
  localparam logic [2:0] c_CMD_ROTATE = 3'd3;
  localparam logic [2:0] c_CMD_START  = 3'd4;
  localparam logic [2:0] c_CMD_DROP   = 3'd5;

  // Pending bit layout: [3] START, [2] ROTATE, [1] LEFT, [0] RIGHT
  localparam logic [3:0] c_PEND_START = 4'b1000;

  logic [1:0]          r_state;
  logic [3:0]          r_pend;
  logic [2:0]          r_mem [fifo_depth_p];
  logic [c_ADDR_W:0]   r_wr_ptr;
  logic [c_ADDR_W:0]   r_rd_ptr;
  logic                r_drop;
  logic                r_rr_drop;   // 1: DROP was the last source granted
  logic                r_v;
  logic [2:0]          r_cmd;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  r_period;

  logic                w_play;
  logic                w_lose;
  logic [3:0]          w_keys;
  logic [3:0]          w_elig;
  logic [3:0]          w_sel_bit;
  logic [2:0]          w_sel_cmd;
  logic [3:0]          w_clr;
  logic                w_wr;
  logic                w_rd;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [c_ADDR_W:0]   w_count;
  logic                w_fifo_has_start;
  logic [c_ADDR_W-1:0] w_idx;
  logic [2:0]          w_head;
  logic                w_xfer;
  logic                w_load;
  logic                w_pick_drop;
  logic                w_tick;
  logic [3:0]          w_pend_nx;
  int                  w_per_raw;
  logic [c_CNT_W-1:0]  w_period;

  assign w_play       = (r_state == c_ST_PLAY);
  assign w_lose       = w_play & lose_i;
  assign w_keys       = {start_i, rotate_i, left_i, right_i};
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                        (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign w_head       = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
  assign w_xfer       = r_v & cmd_ready_i;
  assign w_load       = ~r_v | w_xfer;
  // DROP wins when the FIFO is empty or when the FIFO was granted last
  assign w_pick_drop  = r_drop & (w_fifo_empty | ~r_rr_drop);
  assign w_rd         = ~w_lose & w_load & ~w_pick_drop & ~w_fifo_empty;
  assign w_tick       = w_play & (r_cnt == r_period - c_CNT_W'(1));

  // Gravity period, computed signed so high levels clamp instead of wrapping
  always_comb begin
    w_per_raw = base_period_p - int'({28'd0, level_i}) * step_p;
    w_period  = (w_per_raw < min_period_p) ? c_CNT_W'(min_period_p) : c_CNT_W'(w_per_raw);
  end

  // Stage 2: priority pick of one pending key; only START outside PLAY
  always_comb begin
    w_elig    = w_play ? r_pend : (r_pend & c_PEND_START);
    w_sel_bit = 4'b0000;
    w_sel_cmd = c_CMD_NONE;
    if (w_elig[3]) begin
      w_sel_bit = 4'b1000;
      w_sel_cmd = c_CMD_START;
    end else if (w_elig[2]) begin
      w_sel_bit = 4'b0100;
      w_sel_cmd = c_CMD_ROTATE;
    end else if (w_elig[1]) begin
      w_sel_bit = 4'b0010;
      w_sel_cmd = c_CMD_LEFT;
    end else if (w_elig[0]) begin
      w_sel_bit = 4'b0001;
      w_sel_cmd = c_CMD_RIGHT;
    end
    w_wr  = ~w_fifo_full & (w_elig != 4'b0000);
    w_clr = w_wr ? w_sel_bit : 4'b0000;
  end

  // A START sitting in the FIFO must survive the game-over flush
  always_comb begin
    w_fifo_has_start = 1'b0;
    w_idx            = '0;
    for (int i = 0; i < fifo_depth_p; i++) begin
      w_idx = r_rd_ptr[c_ADDR_W-1:0] + c_ADDR_W'(i);
      if ((i < int'(w_count)) && (r_mem[w_idx] == c_CMD_START)) begin
        w_fifo_has_start = 1'b1;
      end
    end
  end

  // Pending bits: clear-then-set so a same-cycle re-pulse stays pending
  always_comb begin
    if (w_lose) begin
      w_pend_nx = {r_pend[3] | start_i | w_fifo_has_start, 3'b000};
    end else begin
      w_pend_nx = (r_pend & ~w_clr) | w_keys;
      if (!w_play) begin
        w_pend_nx[2:0] = 3'b000;
      end
    end
  end

  // FIFO storage is not reset; the pointers define which entries are live
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= w_sel_cmd;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= c_ST_IDLE;
      r_pend    <= 4'b0000;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_drop    <= 1'b0;
      r_rr_drop <= 1'b0;
      r_v       <= 1'b0;
      r_cmd     <= c_CMD_NONE;
      r_cnt     <= '0;
      r_period  <= w_period;
    end else begin
      r_pend <= w_pend_nx;

      // FSM; lose_i takes precedence over a same-edge START transfer
      case (r_state)
        c_ST_IDLE, c_ST_OVER: begin
          if (w_xfer && (r_cmd == c_CMD_START)) begin
            r_state <= c_ST_PLAY;
          end
        end
        c_ST_PLAY: begin
          if (lose_i) begin
            r_state <= c_ST_OVER;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase

      // Gravity counter: held at 0 outside PLAY, period tracks level there
      if (!w_play || w_lose) begin
        r_cnt    <= '0;
        r_period <= w_period;
      end else if (w_tick) begin
        r_cnt    <= '0;
        r_period <= w_period;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end

      if (w_lose) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_drop   <= 1'b0;
        // Keep only an untransferred START in the output register
        if (!(r_v && !w_xfer && (r_cmd == c_CMD_START))) begin
          r_v <= 1'b0;
        end
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        // A tick while DROP is still outstanding is discarded
        r_drop <= (r_drop & ~(w_load & w_pick_drop)) | (w_tick & ~r_drop);
        if (w_load) begin
          if (w_pick_drop) begin
            r_v       <= 1'b1;
            r_cmd     <= c_CMD_DROP;
            r_rr_drop <= 1'b1;
          end else if (!w_fifo_empty) begin
            r_v       <= 1'b1;
            r_cmd     <= w_head;
            r_rr_drop <= 1'b0;
          end else begin
            r_v <= 1'b0;
          end
        end
      end
    end
  end

  assign cmd_v_o = r_v;
  assign cmd_o   = r_cmd;
  assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_cmd_scheduler
// Purpose  : Directed self-checking bench for key_cmd_scheduler with
//            hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_cmd_scheduler;

  logic       clk = 1'b0;
  logic       reset, left, right, rotate, start, lose, ready;
  logic [3:0] level;
  logic       cmd_v;
  logic [2:0] cmd;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  key_cmd_scheduler #(
    .fifo_depth_p (4),
    .base_period_p(64),
    .step_p       (4),
    .min_period_p (8)
  ) u_dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .left_i     (left),
    .right_i    (right),
    .rotate_i   (rotate),
    .start_i    (start),
    .level_i    (level),
    .lose_i     (lose),
    .cmd_ready_i(ready),
    .cmd_v_o    (cmd_v),
    .cmd_o      (cmd),
    .state_o    (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until cmd_v is seen; n = number of edges taken (max_n on timeout)
  task automatic wait_valid(input int max_n, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while ((cmd_v !== 1'b1) && (n < max_n));
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (cmd_v === 1'b1) n++;
    end
  endtask

  task automatic pulse_key(input int code);
    left   = (code == 1);
    right  = (code == 2);
    rotate = (code == 3);
    start  = (code == 4);
    step();
    left = 0; right = 0; rotate = 0; start = 0;
  endtask

  // Reset, then START through the pipeline: visible after 3 edges, transfer on 4th
  task automatic enter_play();
    reset = 1; ready = 1; level = 0;
    step();
    reset = 0;
    pulse_key(4);
    step();
    step();
    chk("enter_start_v", cmd_v, 1);
    chk("enter_start_cmd", cmd, 4);
    step();
    chk("enter_state", state, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_seq[6];
    int key_seq[6];

    reset = 1; left = 0; right = 0; rotate = 0; start = 0;
    lose = 0; ready = 0; level = 0;
    step();
    step();
    chk("rst_v", cmd_v, 0);
    chk("rst_state", state, 0);
    chk("rst_cmd", cmd, 0);

    // IDLE: LEFT is dropped, START forwarded with 3-edge latency
    reset = 0; ready = 1;
    pulse_key(1);
    pulse_key(4);
    step();
    step();
    chk("idle_start_v", cmd_v, 1);
    chk("idle_start_cmd", cmd, 4);
    chk("idle_state_pre", state, 0);
    step();
    chk("idle_state_post", state, 1);
    chk("idle_v_post", cmd_v, 0);

    // Gravity at level 0: first DROP 65 edges after entering PLAY, then every 64
    wait_valid(100, n);
    chk("drop1_gap", n, 65);
    chk("drop1_cmd", cmd, 5);
    wait_valid(100, n);
    chk("drop2_gap", n, 64);
    level = 15;
    wait_valid(100, n);
    chk("drop3_gap", n, 64);
    wait_valid(100, n);
    chk("drop4_gap", n, 8);
    chk("drop4_cmd", cmd, 5);
    wait_valid(100, n);
    chk("drop5_gap", n, 8);

    // Three keys on one cycle leave in priority order
    level = 0;
    enter_play();
    left = 1; rotate = 1; right = 1;
    step();
    left = 0; rotate = 0; right = 0;
    step();
    chk("pri_v0", cmd_v, 0);
    step();
    chk("pri_cmd0", cmd, 3);
    step();
    chk("pri_cmd1", cmd, 1);
    step();
    chk("pri_cmd2", cmd, 2);
    chk("pri_v2", cmd_v, 1);
    step();
    chk("pri_v3", cmd_v, 0);

    // Backpressure: 1 in output reg, 4 in FIFO, 1 pending, one DROP outstanding
    enter_play();
    ready = 0;
    key_seq = '{1, 2, 3, 1, 2, 3};
    for (int i = 0; i < 6; i++) begin
      pulse_key(key_seq[i]);
      step();
    end
    repeat (288) step();
    chk("bp_hold_v", cmd_v, 1);
    chk("bp_hold_cmd", cmd, 1);
    ready = 1;
    exp_seq = '{5, 2, 3, 1, 2, 3};
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("bp_rel%0d_cmd", i), cmd, exp_seq[i]);
      chk($sformatf("bp_rel%0d_v", i), cmd_v, 1);
    end
    step();
    chk("bp_drained_v", cmd_v, 0);

    // Game over flushes queued work; LEFT ignored; START resumes
    ready = 0;
    left = 1; right = 1; rotate = 1;
    step();
    left = 0; right = 0; rotate = 0;
    step();
    step();
    step();
    chk("lose_pre_cmd", cmd, 3);
    lose = 1;
    step();
    lose = 0;
    chk("lose_state", state, 2);
    chk("lose_v", cmd_v, 0);
    ready = 1;
    pulse_key(1);
    count_valid(8, n);
    chk("over_left_count", n, 0);
    chk("over_state", state, 2);
    pulse_key(4);
    step();
    step();
    chk("over_start_cmd", cmd, 4);
    step();
    chk("over_replay_state", state, 1);

    // A START waiting in the output register survives game over
    ready = 0;
    pulse_key(4);
    step();
    step();
    chk("keep_pre_v", cmd_v, 1);
    lose = 1;
    step();
    lose = 0;
    chk("keep_state", state, 2);
    chk("keep_v", cmd_v, 1);
    chk("keep_cmd", cmd, 4);
    ready = 1;
    step();
    chk("keep_replay_state", state, 1);

    // Reset while stalled, START pulse on the reset edge is ignored
    ready = 0;
    pulse_key(1);
    step();
    step();
    chk("mid_v", cmd_v, 1);
    chk("mid_cmd", cmd, 1);
    reset = 1; start = 1;
    step();
    reset = 0; start = 0;
    chk("mid_rst_v", cmd_v, 0);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_cmd", cmd, 0);
    ready = 1;
    count_valid(10, n);
    chk("mid_stale_count", n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_cmd_scheduler.md
KEY_CMD_SCHEDULER -- requirements
Module: key_cmd_scheduler

Interface
REQ-001 SHALL have parameter fifo_depth_p, default 4, command FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter base_period_p, default 64, gravity period in clk_i cycles at level 0.
REQ-003 SHALL have parameter step_p, default 4, period reduction per level.
REQ-004 SHALL have parameter min_period_p, default 8, gravity period floor.
REQ-005 clk_i  input  1  sole clock; all logic rising-edge.
REQ-006 reset_i  input  1  synchronous, active-high reset.
REQ-007 left_i, right_i, rotate_i, start_i  input  1 each  single-cycle key-edge pulses.
REQ-008 level_i  input  4  game level, sampled at each gravity reload.
REQ-009 lose_i  input  1  game-over indication from game logic.
REQ-010 cmd_ready_i  input  1  consumer accepts cmd_o this cycle.
REQ-011 cmd_v_o  output  1  cmd_o valid.
REQ-012 cmd_o  output  3  command: 1 LEFT, 2 RIGHT, 3 ROTATE, 4 START, 5 DROP.
REQ-013 state_o  output  2  0 IDLE, 1 PLAY, 2 OVER.

Function
REQ-014 A transfer SHALL occur on a rising edge with cmd_v_o=1 and cmd_ready_i=1; cmd_o and cmd_v_o SHALL stay stable until the transfer.
REQ-015 Stage 1: each key pulse SHALL set a sticky per-key pending bit; a pulse on a key whose bit is already set SHALL be merged (no second command).
REQ-016 Stage 2: each cycle the FIFO is not full, the highest-priority pending bit SHALL be cleared and its command written to the FIFO; priority START > ROTATE > LEFT > RIGHT.
REQ-017 FIFO full: pending bits SHALL be held, not lost; a bit cleared and set in the same cycle SHALL end set.
REQ-018 Stage 3: the output register SHALL load when empty or being transferred, choosing between FIFO head and drop_pending round-robin (the last-granted source loses a tie; after reset DROP wins the first tie).
REQ-019 Key latency with all stages empty and cmd_ready_i=1: pulse sampled at edge t, cmd_v_o=1 after edge t+2, transfer at edge t+3.
REQ-020 Gravity counter SHALL run only in PLAY, counting 0..P-1, P = max(base_period_p - level_i*step_p, min_period_p), computed wide enough not to wrap negative.
REQ-021 At count P-1 the counter SHALL wrap to 0, reload P from the current level_i, and set drop_pending; if drop_pending is already set the tick SHALL be discarded (at most one outstanding DROP).
REQ-022 FSM IDLE: only START is forwarded; other keys SHALL be cleared from pending and never enqueued; gravity counter held at 0.
REQ-023 IDLE->PLAY on transfer of START; the gravity counter SHALL start from 0 on the next cycle.
REQ-024 PLAY->OVER when lose_i=1; on that edge the FIFO, pending bits, drop_pending and an untransferred output register SHALL be flushed, except a START, which SHALL be kept.
REQ-025 OVER behaves as IDLE; OVER->PLAY on transfer of START.
REQ-026 START transferred in PLAY SHALL be forwarded and SHALL leave the state at PLAY.
REQ-027 lose_i and a START transfer on the same edge in PLAY: the state SHALL go to OVER.

Reset
REQ-028 reset_i=1 at a rising edge SHALL, on that edge, clear pending bits, FIFO pointers, drop_pending, gravity counter and round-robin pointer, set state_o=IDLE and cmd_v_o=0, and load cmd_o=0, including mid-transfer and mid-play.
REQ-029 Key pulses on a reset edge SHALL be ignored.

Verification
REQ-030 IDLE, left_i pulse then start_i pulse, ready=1 -> only cmd_o=4 emitted; state_o=1 after transfer; no LEFT.
REQ-031 PLAY, level_i=0, ready=1, no keys -> cmd_o=5 every 64 cycles; level_i=15 -> every 8 cycles (floor).
REQ-032 PLAY, left_i, rotate_i, right_i pulsed same cycle, ready=1 -> cmd_o sequence 3,1,2, one per cycle.
REQ-033 PLAY, ready=0 for 300 cycles, 6 distinct key pulses on separate cycles -> 4 commands in FIFO, 1 in output register, 1 pending; exactly one DROP outstanding; all released in order once ready=1.
REQ-034 PLAY, lose_i=1 with queued commands -> state_o=2, cmd_v_o=0 next cycle; further LEFT ignored; START -> PLAY.
REQ-035 reset_i pulse while cmd_v_o=1 and ready=0 -> next cycle cmd_v_o=0, state_o=0, no stale command later.
